// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional checksum trailer is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

  localparam int IMEM_ADDR_W = 10;
  localparam int IMEM_BYTES  = 1024;

  // Big-endian lanes: the byte at word address +0 lives in the top lane.
  localparam int LANE_W     = 8;
  localparam int WORD_LANES = 4;
  localparam int LANE0_LSB  = 24;
  localparam int LANE1_LSB  = 16;
  localparam int LANE2_LSB  = 8;
  localparam int LANE3_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_PAYLOAD,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/byte_to_word_packer.sv
// Collects big-endian bytes into 32-bit words; word_ready flags the byte
// that completes a word, with the full word presented on the same cycle.
module byte_to_word_packer
  import imem_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [LANE_W-1:0]            byte_in,
  output logic [WORD_LANES*LANE_W-1:0] word,
  output logic                         word_ready
);

  localparam int HELD_W = (WORD_LANES - 1) * LANE_W;

  logic [HELD_W-1:0] held;
  logic [1:0]        count;

  // Earlier bytes already sit in the upper lanes; the incoming byte fills lane 3.
  assign word       = {held, byte_in};
  assign word_ready = push && (count == 2'(WORD_LANES - 1));

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst || clear) begin
      held  <= '0;
      count <= '0;
    end else if (push) begin
      held  <= {held[HELD_W-LANE_W-1:0], byte_in};
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: length-prefixed byte stream -> big-endian word writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int MEM_BYTES = IMEM_BYTES,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  localparam logic [31:0] ROOM = 32'(MEM_BYTES - BASE_ADDR);

  state_t      state;
  logic [15:0] len;
  logic        len_loaded;
  logic        take;
  logic        restartable;
  logic        pack_clear;
  logic        pack_push;
  logic        word_ready;
  logic [31:0] word;
  logic [31:0] len_bytes;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign take        = in_valid && in_ready;
  assign restartable = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign pack_clear  = start && restartable;
  assign pack_push   = take && (state == ST_PAYLOAD);
  assign len_bytes   = {14'd0, len, 2'b00};

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .push       (pack_push),
    .byte_in    (in_byte),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
      len           <= '0;
      len_loaded    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      // NOTE: default first; the one branch that writes overrides it later in the block.
      mem_we <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state         <= ST_LEN_HI;
            in_ready      <= 1'b1;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            len           <= '0;
            len_loaded    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
        end

        ST_LEN_HI: begin
          if (take) begin
            len[15:8] <= in_byte;
            state     <= ST_LEN_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= csum ^ in_byte;
`endif
          end
        end

        // Capture cycle, then one evaluation cycle with the stream paused.
        ST_LEN_LO: begin
          if (!len_loaded) begin
            if (take) begin
              len[7:0]   <= in_byte;
              len_loaded <= 1'b1;
              in_ready   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum       <= csum ^ in_byte;
`endif
            end
          end else begin
            len_loaded <= 1'b0;
            if (len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state    <= ST_CSUM;
              in_ready <= 1'b1;
`else
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
`endif
            end else if (len_bytes > ROOM) begin
              state <= ST_ERR;
              error <= 1'b1;
            end else begin
              state    <= ST_PAYLOAD;
              in_ready <= 1'b1;
            end
          end
        end

        ST_PAYLOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (take) begin
            csum <= csum ^ in_byte;
          end
`endif
          if (word_ready) begin
            state     <= ST_WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(32'(BASE_ADDR) + {14'd0, words_written, 2'b00});
            mem_wdata <= word;
          end
        end

        ST_WRITE: begin
          words_written <= words_written + 16'd1;
          if (words_written + 16'd1 == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= ST_CSUM;
            in_ready <= 1'b1;
`else
            state    <= ST_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state    <= ST_PAYLOAD;
            in_ready <= 1'b1;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (take) begin
            in_ready <= 1'b0;
            if (in_byte == csum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
